// File: rtl/vga_grid_renderer_if.sv
// Signal bundle between the game controller / VGA DAC side and the grid renderer.
// The renderer takes the slave view; the game side (or a bench) takes the master view.
interface vga_grid_renderer_if #(
  parameter int POS_W = 4
);
  logic             in_game;
  logic             hit;
  logic [POS_W-1:0] position;
  logic             o_hsync;
  logic             o_vsync;
  logic [3:0]       o_red;
  logic [3:0]       o_green;
  logic [3:0]       o_blue;
  logic             o_frame_start;

  modport master (
    output in_game, hit, position,
    input  o_hsync, o_vsync, o_red, o_green, o_blue, o_frame_start
  );

  modport slave (
    input  in_game, hit, position,
    output o_hsync, o_vsync, o_red, o_green, o_blue, o_frame_start
  );
endinterface

// File: rtl/vga_grid_renderer.sv
// VGA timing generator drawing a ROWS x COLS board with one marked target cell.
// Game inputs are sampled once per frame; pixels leave through a 2-stage pipeline.
module vga_grid_renderer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int GRID_X0      = 135,
  parameter int GRID_Y0      = 45,
  parameter int CELL         = 120,
  parameter int GAP          = 5,
  parameter int INSET        = 30,
  parameter int FLASH_FRAMES = 30,
  parameter int POS_W        = 4
) (
  input  logic               clk25MHz,
  input  logic               rst,
  vga_grid_renderer_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(FLASH_FRAMES + 1);
  localparam int PITCH   = CELL + GAP;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLASH = 1'b1;

  function automatic logic in_span(input int a, input int lo, input int len);
    return (a >= lo) && (a < lo + len);
  endfunction

  function automatic logic on_grid(input int a, input int org, input int n);
    logic any;
    any = 1'b0;
    for (int i = 0; i < n; i++)
      if (in_span(a, org + i * PITCH, CELL)) any = 1'b1;
    return any;
  endfunction

  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic             frame_end;
  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             hit_q;
  logic             hit_rise;
  logic [POS_W-1:0] pos_s;
  logic             game_s;
  logic             flash_s;

  assign frame_end = (h == HW'(H_TOTAL - 1)) && (v == VW'(V_TOTAL - 1));
  assign hit_rise  = bus.hit & ~hit_q;

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Shadow registers sample the pre-edge flash state; a hit reload beats the frame decrement.
  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hit_q   <= 1'b0;
      pos_s   <= '0;
      game_s  <= 1'b0;
      flash_s <= 1'b0;
    end else begin
      hit_q <= bus.hit;
      if (frame_end) begin
        pos_s   <= bus.position;
        game_s  <= bus.in_game;
        flash_s <= (state == S_FLASH);
      end
      if (!bus.in_game) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (hit_rise) begin
        state <= S_FLASH;
        cnt   <= CW'(FLASH_FRAMES);
      end else if (state == S_FLASH && bus.o_frame_start) begin
        if (cnt <= CW'(1)) begin
          state <= S_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  int   p;
  int   tc;
  int   tr;
  logic tgt_ok;

  always_comb begin
    tgt_ok = (pos_s != '0) && (32'(pos_s) <= 32'(ROWS * COLS));
    p      = tgt_ok ? 32'(pos_s) - 1 : 0;
    tc     = p / ROWS;
    tr     = ROWS - 1 - (p % ROWS);
  end

  int   hx;
  int   vy;
  logic active;
  logic in_cell;
  logic in_mark;
  logic hs;
  logic vs;
  logic fs;

  always_comb begin
    hx      = 32'(h);
    vy      = 32'(v);
    active  = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    in_cell = on_grid(hx, GRID_X0, COLS) && on_grid(vy, GRID_Y0, ROWS);
    in_mark = tgt_ok
              && in_span(hx, GRID_X0 + tc * PITCH + INSET, CELL - 2 * INSET)
              && in_span(vy, GRID_Y0 + tr * PITCH + INSET, CELL - 2 * INSET);
    hs      = in_span(hx, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : !SYNC_POL;
    vs      = in_span(vy, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : !SYNC_POL;
    fs      = (h == '0) && (v == '0);
  end

  // Stage 1: region and cell decode
  logic vld_p1;
  logic cell_p1;
  logic mark_p1;
  logic hs_p1;
  logic vs_p1;
  logic fs_p1;

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= !SYNC_POL;
      vs_p1  <= !SYNC_POL;
      fs_p1  <= 1'b0;
    end else begin
      vld_p1 <= active;
      hs_p1  <= hs;
      vs_p1  <= vs;
      fs_p1  <= fs;
    end
  end

  always_ff @(posedge clk25MHz) begin
    cell_p1 <= in_cell;
    mark_p1 <= in_mark;
  end

  // Stage 2: colour
  logic [11:0] rgb;

  always_comb begin
    rgb = '0;
    if (vld_p1) begin
      if (!game_s) rgb = cell_p1 ? 12'hFFF : 12'h000;
      else if (mark_p1) rgb = flash_s ? 12'hF00 : 12'h0F0;
    end
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      bus.o_hsync       <= !SYNC_POL;
      bus.o_vsync       <= !SYNC_POL;
      bus.o_frame_start <= 1'b0;
      bus.o_red         <= '0;
      bus.o_green       <= '0;
      bus.o_blue        <= '0;
    end else begin
      bus.o_hsync       <= hs_p1;
      bus.o_vsync       <= vs_p1;
      bus.o_frame_start <= fs_p1;
      bus.o_red         <= rgb[11:8];
      bus.o_green       <= rgb[7:4];
      bus.o_blue        <= rgb[3:0];
    end
  end
endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed bench for vga_grid_renderer using a shrunken raster so many frames fit in a short run.
module tb_vga_grid_renderer;
  localparam int HA = 40, HF = 2, HS = 4, HB = 2;
  localparam int VA = 30, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  vga_grid_renderer_if #(.POS_W(4)) vif ();

  vga_grid_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .ROWS(3), .COLS(3), .GRID_X0(5), .GRID_Y0(2),
    .CELL(8), .GAP(2), .INSET(2), .FLASH_FRAMES(3), .POS_W(4)
  ) dut (
    .clk25MHz(clk),
    .rst     (rst),
    .bus     (vif)
  );

  always #20 clk = ~clk;

  // Clocks since reset release: after edge n the outputs show raster index n-2.
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct {
    logic        game;
    logic [3:0]  pos;
    int          x;
    int          y;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 20 * FRAME) begin
      @(negedge clk);
      guard++;
    end
  endtask

  function automatic int cur_frame();
    return cyc / FRAME;
  endfunction

  task automatic check_px(input string name, input int fr, input int x, input int y,
                          input logic [11:0] exp);
    int target;
    target = fr * FRAME + y * HT + x + 2;
    if (cyc >= target) begin
      chk({name, "_late"}, 32'(cyc), 32'(target - 1));
    end else begin
      wait_cyc(target);
      chk(name, {20'd0, vif.o_red, vif.o_green, vif.o_blue}, {20'd0, exp});
    end
  endtask

  task automatic pulse_hit();
    vif.hit = 1'b1;
    repeat (3) @(negedge clk);
    vif.hit = 1'b0;
  endtask

  initial begin
    int hs_bad, vs_bad, fs_bad, hs_low, idx, hh, vv, f;

    // marker cells with CELL 8, GAP 2, INSET 2: col c x 7+10c..10+10c, row r y 4+10r..7+10r
    tbl[0]  = '{1'b0, 4'd0,  5,  2, 12'hFFF};
    tbl[1]  = '{1'b0, 4'd0, 13,  2, 12'h000};
    tbl[2]  = '{1'b0, 4'd0,  4,  2, 12'h000};
    tbl[3]  = '{1'b0, 4'd0, 32, 29, 12'hFFF};
    tbl[4]  = '{1'b0, 4'd0, 41,  5, 12'h000};
    tbl[5]  = '{1'b1, 4'd1,  7, 24, 12'h0F0};
    tbl[6]  = '{1'b1, 4'd1,  6, 24, 12'h000};
    tbl[7]  = '{1'b1, 4'd1, 10, 27, 12'h0F0};
    tbl[8]  = '{1'b1, 4'd1, 11, 27, 12'h000};
    tbl[9]  = '{1'b1, 4'd9, 27,  4, 12'h0F0};
    tbl[10] = '{1'b1, 4'd9, 30,  7, 12'h0F0};
    tbl[11] = '{1'b1, 4'd9,  7, 24, 12'h000};
    tbl[12] = '{1'b1, 4'd5, 17, 14, 12'h0F0};
    tbl[13] = '{1'b1, 4'd3,  7,  4, 12'h0F0};
    tbl[14] = '{1'b1, 4'd12, 37, 5, 12'h000};
    tbl[15] = '{1'b1, 4'd10, 37, 25, 12'h000};
    tbl[16] = '{1'b0, 4'd1,  7, 24, 12'hFFF};

    vif.in_game  = 1'b0;
    vif.hit      = 1'b0;
    vif.position = 4'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", 32'(vif.o_hsync), 32'd1);
    chk("rst_vsync", 32'(vif.o_vsync), 32'd1);
    chk("rst_frame_start", 32'(vif.o_frame_start), 32'd0);
    chk("rst_rgb", {20'd0, vif.o_red, vif.o_green, vif.o_blue}, 32'd0);
    rst = 1'b1;

    hs_bad = 0; vs_bad = 0; fs_bad = 0; hs_low = 0;
    for (int i = 0; i <= FRAME; i++) begin
      wait_cyc(i + 2);
      idx = i % FRAME;
      hh  = idx % HT;
      vv  = idx / HT;
      if (vif.o_hsync !== !(hh >= HA + HF && hh < HA + HF + HS)) hs_bad++;
      if (vif.o_vsync !== !(vv >= VA + VF && vv < VA + VF + VS)) vs_bad++;
      if (vif.o_frame_start !== (idx == 0)) fs_bad++;
      if (i < HT && vif.o_hsync === 1'b0) hs_low++;
    end
    chk("hsync_pattern", 32'(hs_bad), 32'd0);
    chk("vsync_pattern", 32'(vs_bad), 32'd0);
    chk("frame_start_pattern", 32'(fs_bad), 32'd0);
    chk("hsync_low_per_line", 32'(hs_low), 32'(HS));

    for (int i = 0; i < 17; i++) begin
      vif.in_game  = tbl[i].game;
      vif.position = tbl[i].pos;
      check_px($sformatf("vec%0d", i), cur_frame() + 1, tbl[i].x, tbl[i].y, tbl[i].rgb);
    end

    // Flash lasting three frames after a mid-frame hit.
    vif.in_game  = 1'b1;
    vif.position = 4'd1;
    check_px("flash_pre", cur_frame() + 1, 8, 25, 12'h0F0);
    f = cur_frame();
    pulse_hit();
    check_px("flash_f1", f + 1, 8, 25, 12'hF00);
    check_px("flash_f2", f + 2, 8, 25, 12'hF00);
    check_px("flash_f3", f + 3, 8, 25, 12'hF00);
    check_px("flash_end", f + 4, 8, 25, 12'h0F0);

    // Second edge during frame 2 restarts the three-frame count.
    f = cur_frame();
    pulse_hit();
    check_px("ext_f1", f + 1, 8, 25, 12'hF00);
    check_px("ext_f2", f + 2, 8, 25, 12'hF00);
    pulse_hit();
    check_px("ext_f3", f + 3, 8, 25, 12'hF00);
    check_px("ext_f5", f + 5, 8, 25, 12'hF00);
    check_px("ext_end", f + 6, 8, 25, 12'h0F0);

    // in_game dropping mid-flash clears the flash for good.
    f = cur_frame();
    pulse_hit();
    check_px("drop_red", f + 1, 8, 25, 12'hF00);
    vif.in_game = 1'b0;
    check_px("drop_white", f + 2, 8, 25, 12'hFFF);
    vif.in_game = 1'b1;
    check_px("drop_green", f + 3, 8, 25, 12'h0F0);

    // Mid-frame reset.
    vif.in_game = 1'b0;
    check_px("mrst_pre", cur_frame() + 1, 7, 22, 12'hFFF);
    rst = 1'b0;
    #1;
    chk("mrst_rgb", {20'd0, vif.o_red, vif.o_green, vif.o_blue}, 32'd0);
    chk("mrst_frame_start", 32'(vif.o_frame_start), 32'd0);
    repeat (10) @(negedge clk);
    chk("mrst_hsync", 32'(vif.o_hsync), 32'd1);
    chk("mrst_vsync", 32'(vif.o_vsync), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_fs_clk1", 32'(vif.o_frame_start), 32'd0);
    @(negedge clk);
    chk("mrst_fs_clk2", 32'(vif.o_frame_start), 32'd1);
    @(negedge clk);
    chk("mrst_fs_clk3", 32'(vif.o_frame_start), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
